// File: rtl/crc_req_arb_if.sv
// -----------------------------------------------------------------------------
// crc_req_arb_if
// Bundles the client request/completion streams, the CRC engine request/done
// handshake and the interrupt/error signals of crc_req_arb.
//
// Modports:
//   slave  - the arbiter side (crc_req_arb drives the o_* signals)
//   master - the environment side (clients, engine, interrupt controller)
//
// Signal summary:
//   i_ch_req_valid/i_ch_req_data/o_ch_req_ready : per-channel request streams
//   o_crc_req_valid/o_crc_req_data/i_crc_req_ready : engine request {chan_id, payload}
//   i_crc_done_valid/i_crc_done_data/o_crc_done_ready : engine completion {chan_id, result}
//   o_ch_done_valid/o_ch_done_data/i_ch_done_ready : per-channel completions
//   i_int_mask/i_int_clr/o_int_pend/o_int : completion interrupt
//   o_err : sticky protocol error
// -----------------------------------------------------------------------------
interface crc_req_arb_if #(
    parameter int NUM_CH = 4,
    parameter int REQ_W  = 36,
    parameter int RSP_W  = 149,
    parameter int CHID_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
);
    logic [NUM_CH-1:0]       i_ch_req_valid;
    logic [NUM_CH*REQ_W-1:0] i_ch_req_data;
    logic [NUM_CH-1:0]       o_ch_req_ready;

    logic                    o_crc_req_valid;
    logic [CHID_W+REQ_W-1:0] o_crc_req_data;
    logic                    i_crc_req_ready;

    logic                    i_crc_done_valid;
    logic [CHID_W+RSP_W-1:0] i_crc_done_data;
    logic                    o_crc_done_ready;

    logic [NUM_CH-1:0]       o_ch_done_valid;
    logic [RSP_W-1:0]        o_ch_done_data;
    logic [NUM_CH-1:0]       i_ch_done_ready;

    logic [NUM_CH-1:0]       i_int_mask;
    logic [NUM_CH-1:0]       i_int_clr;
    logic [NUM_CH-1:0]       o_int_pend;
    logic                    o_int;
    logic                    o_err;

    modport slave (
        input  i_ch_req_valid, i_ch_req_data, i_crc_req_ready,
        input  i_crc_done_valid, i_crc_done_data, i_ch_done_ready,
        input  i_int_mask, i_int_clr,
        output o_ch_req_ready, o_crc_req_valid, o_crc_req_data,
        output o_crc_done_ready, o_ch_done_valid, o_ch_done_data,
        output o_int_pend, o_int, o_err
    );

    modport master (
        output i_ch_req_valid, i_ch_req_data, i_crc_req_ready,
        output i_crc_done_valid, i_crc_done_data, i_ch_done_ready,
        output i_int_mask, i_int_clr,
        input  o_ch_req_ready, o_crc_req_valid, o_crc_req_data,
        input  o_crc_done_ready, o_ch_done_valid, o_ch_done_data,
        input  o_int_pend, o_int, o_err
    );
endinterface

// File: rtl/crc_req_arb.sv
// -----------------------------------------------------------------------------
// crc_req_arb
// N-channel front end for the CRC engine request/done handshake.
//   - Round-robin arbitration of NUM_CH client request streams into a single
//     one-entry engine request stage; each beat is tagged with its channel ID.
//   - Tagged engine completions are routed combinationally back to the owner.
//   - Per-channel outstanding counters limit each client to MAX_OUT requests.
//   - Maskable completion interrupt, sticky protocol error.
//
// Ports:
//   i_clk      : clock
//   i_reset    : synchronous active-high reset
//   bus        : crc_req_arb_if.slave (request, completion, interrupt, error)
//   o_timeout  : sticky watchdog flag (only with CRC_ARB_TIMEOUT_EN)
//
// Optional feature macro: CRC_ARB_TIMEOUT_EN
//   Adds a watchdog that counts cycles while requests are outstanding and no
//   completion is accepted; at TIMEOUT_CYC it sets o_timeout, which also forces
//   o_int regardless of i_int_mask.
//
// Request stage states:
//   state    | meaning
//   ST_EMPTY | no beat held, a grant may load the stage
//   ST_FULL  | beat presented to the engine, held until i_crc_req_ready
// -----------------------------------------------------------------------------
module crc_req_arb #(
    parameter int NUM_CH      = 4,
    parameter int REQ_W       = 36,
    parameter int RSP_W       = 149,
    parameter int MAX_OUT     = 4,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic         i_clk,
    input  logic         i_reset,
    crc_req_arb_if.slave bus
`ifdef CRC_ARB_TIMEOUT_EN
    ,
    output logic         o_timeout
`endif
);
    localparam int CHID_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int CNT_W  = $clog2(MAX_OUT + 1);

    if (NUM_CH < 1 || NUM_CH > 16) begin : g_bad_num_ch
        $error("crc_req_arb: NUM_CH must be 1..16");
    end
    if (MAX_OUT < 1 || MAX_OUT > 15) begin : g_bad_max_out
        $error("crc_req_arb: MAX_OUT must be 1..15");
    end
    if (TIMEOUT_CYC < 1) begin : g_bad_timeout
        $error("crc_req_arb: TIMEOUT_CYC must be positive");
    end

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } stage_e;

    stage_e                  stage_q;
    logic [CHID_W+REQ_W-1:0] stage_data_q;
    logic [CHID_W-1:0]       rr_q;          // first channel to search next
    logic [CNT_W-1:0]        cnt_q [NUM_CH];
    logic [CNT_W-1:0]        cnt_d [NUM_CH];
    logic [NUM_CH-1:0]       pend_q;
    logic                    int_q;
    logic                    err_q;

    // ---------------------------------------------------------------- grant
    logic                    may_load;
    logic [NUM_CH-1:0]       elig;
    logic [NUM_CH-1:0]       grant_vec;
    logic                    grant_any;
    logic [CHID_W-1:0]       grant_id;
    logic [CHID_W-1:0]       rr_d;
    logic [REQ_W-1:0]        grant_data;

    always_comb begin
        may_load = (stage_q == ST_EMPTY) || bus.i_crc_req_ready;
        for (int k = 0; k < NUM_CH; k++) begin
            elig[k] = bus.i_ch_req_valid[k] && (cnt_q[k] < CNT_W'(MAX_OUT));
        end
    end

    always_comb begin
        int idx;
        idx       = 0;
        grant_vec = '0;
        grant_any = 1'b0;
        grant_id  = '0;
        // No grant during reset so no client sees a handshake that is lost.
        if (may_load && !i_reset) begin
            for (int j = 0; j < NUM_CH; j++) begin
                idx = (int'(rr_q) + j) % NUM_CH;
                if (!grant_any && elig[idx]) begin
                    grant_any      = 1'b1;
                    grant_id       = CHID_W'(idx);
                    grant_vec[idx] = 1'b1;
                end
            end
        end
    end

    always_comb begin
        rr_d       = (int'(grant_id) == NUM_CH - 1) ? '0 : grant_id + 1'b1;
        grant_data = bus.i_ch_req_data[int'(grant_id)*REQ_W +: REQ_W];
    end

    // ------------------------------------------------------- completion path
    logic [CHID_W-1:0]       done_id;
    logic                    done_id_ok;
    logic [NUM_CH-1:0]       done_valid_vec;
    logic [NUM_CH-1:0]       done_hs;
    logic                    done_ready;
    logic                    done_bad;

    always_comb begin
        done_id        = bus.i_crc_done_data[CHID_W+RSP_W-1 -: CHID_W];
        done_id_ok     = int'(done_id) < NUM_CH;
        done_valid_vec = '0;
        done_hs        = '0;
        // Beats tagged with a nonexistent channel are swallowed.
        done_ready     = 1'b1;
        if (done_id_ok) begin
            done_valid_vec[done_id] = bus.i_crc_done_valid;
            done_ready              = bus.i_ch_done_ready[done_id];
            done_hs[done_id]        = bus.i_crc_done_valid && bus.i_ch_done_ready[done_id];
        end
        done_bad = bus.i_crc_done_valid && !done_id_ok;
    end

    // ---------------------------------------------------- outstanding counts
    logic underflow;

    always_comb begin
        underflow = 1'b0;
        for (int k = 0; k < NUM_CH; k++) begin
            cnt_d[k] = cnt_q[k];
            if (grant_vec[k] && !done_hs[k]) begin
                cnt_d[k] = cnt_q[k] + 1'b1;
            end else if (done_hs[k] && !grant_vec[k] && cnt_q[k] != '0) begin
                cnt_d[k] = cnt_q[k] - 1'b1;
            end
            // A completion nobody asked for is still delivered, but flagged.
            if (done_hs[k] && cnt_q[k] == '0) begin
                underflow = 1'b1;
            end
        end
    end

    // ------------------------------------------------------------ registers
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            stage_q      <= ST_EMPTY;
            stage_data_q <= '0;
            rr_q         <= '0;
            for (int k = 0; k < NUM_CH; k++) begin
                cnt_q[k] <= '0;
            end
            pend_q       <= '0;
            int_q        <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            case (stage_q)
                ST_EMPTY: if (grant_any) stage_q <= ST_FULL;
                ST_FULL:  if (bus.i_crc_req_ready && !grant_any) stage_q <= ST_EMPTY;
                default:  stage_q <= ST_EMPTY;
            endcase
            if (grant_any) begin
                stage_data_q <= {grant_id, grant_data};
                rr_q         <= rr_d;
            end
            for (int k = 0; k < NUM_CH; k++) begin
                cnt_q[k] <= cnt_d[k];
            end
            // Set wins over a same-cycle clear.
            pend_q <= (pend_q & ~bus.i_int_clr) | done_hs;
            int_q  <= |(pend_q & bus.i_int_mask);
            err_q  <= err_q | done_bad | underflow;
        end
    end

    assign bus.o_ch_req_ready   = grant_vec;
    assign bus.o_crc_req_valid  = (stage_q == ST_FULL);
    assign bus.o_crc_req_data   = stage_data_q;
    assign bus.o_crc_done_ready = done_ready;
    assign bus.o_ch_done_valid  = done_valid_vec;
    assign bus.o_ch_done_data   = bus.i_crc_done_data[RSP_W-1:0];
    assign bus.o_int_pend       = pend_q;
    assign bus.o_err            = err_q;

`ifdef CRC_ARB_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYC + 1);

    logic [WD_W-1:0] wd_q;
    logic            timeout_q;
    logic            any_out;

    always_comb begin
        any_out = 1'b0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (cnt_q[k] != '0) any_out = 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            wd_q      <= '0;
            timeout_q <= 1'b0;
        end else if ((|done_hs) || !any_out) begin
            wd_q <= '0;
        end else if (wd_q != WD_W'(TIMEOUT_CYC)) begin
            wd_q <= wd_q + 1'b1;
            if (wd_q == WD_W'(TIMEOUT_CYC - 1)) begin
                timeout_q <= 1'b1;
            end
        end
    end

    assign o_timeout = timeout_q;
    assign bus.o_int = int_q | timeout_q;
`else
    assign bus.o_int = int_q;
`endif

endmodule

// File: tb/tb_crc_req_arb.sv
module tb_crc_req_arb;
    localparam int NCH = 4;
    localparam int RQW = 36;
    localparam int RSW = 149;

    logic clk = 1'b0;
    logic rst = 1'b1;
`ifdef CRC_ARB_TIMEOUT_EN
    logic timeout;
`endif

    always #5 clk = ~clk;

    crc_req_arb_if #(.NUM_CH(NCH), .REQ_W(RQW), .RSP_W(RSW)) bus4 ();
    crc_req_arb_if #(.NUM_CH(3),   .REQ_W(RQW), .RSP_W(RSW)) bus3 ();

    crc_req_arb #(
        .NUM_CH(NCH), .REQ_W(RQW), .RSP_W(RSW), .MAX_OUT(4), .TIMEOUT_CYC(16)
    ) u_dut (
        .i_clk(clk),
        .i_reset(rst),
        .bus(bus4)
`ifdef CRC_ARB_TIMEOUT_EN
        ,
        .o_timeout(timeout)
`endif
    );

    // Three-channel instance: its 2-bit tag can carry id 3, which is invalid.
    crc_req_arb #(
        .NUM_CH(3), .REQ_W(RQW), .RSP_W(RSW), .MAX_OUT(4), .TIMEOUT_CYC(16)
`ifdef CRC_ARB_TIMEOUT_EN
    ) u_dut3 (.i_clk(clk), .i_reset(rst), .bus(bus3), .o_timeout());
`else
    ) u_dut3 (.i_clk(clk), .i_reset(rst), .bus(bus3));
`endif

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [255:0] act, input logic [255:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Reference model state
    int          m_rr;
    int          m_cnt [NCH];
    logic        m_full;
    logic [3:0]  m_pend;
    logic        m_int;
    logic        m_err;
    logic [37:0] exp_q [$];
    int          seen_ids [$];
`ifdef CRC_ARB_TIMEOUT_EN
    int          m_wd;
    logic        m_to;
`endif

    task automatic model_reset();
        m_rr   = 0;
        m_full = 1'b0;
        m_pend = '0;
        m_int  = 1'b0;
        m_err  = 1'b0;
        for (int c = 0; c < NCH; c++) m_cnt[c] = 0;
        exp_q.delete();
`ifdef CRC_ARB_TIMEOUT_EN
        m_wd = 0;
        m_to = 1'b0;
`endif
    endtask

    task automatic new_req_data();
        for (int c = 0; c < NCH; c++) begin
            bus4.i_ch_req_data[c*RQW +: RQW] = {4'(c), 32'($urandom)};
        end
    endtask

    task automatic set_done(input logic v, input int id, input logic [3:0] rdy);
        bus4.i_crc_done_valid = v;
        bus4.i_crc_done_data  = {2'(id), 117'd0, 32'($urandom)};
        bus4.i_ch_done_ready  = rdy;
    endtask

    // One clock cycle: compare all outputs against the model at the falling
    // edge, advance the model, then move to just after the next rising edge.
    task automatic tick();
        int         g;
        int         id;
        int         c;
        logic [3:0] exp_rdy;
        logic [3:0] exp_dv;
        logic [3:0] hs;
        logic       exp_dr;
        logic       any_out;
        @(negedge clk);
        chk("req_valid", bus4.o_crc_req_valid, m_full);
        if (m_full && exp_q.size() > 0) begin
            chk("req_data", bus4.o_crc_req_data, exp_q[0]);
            if (bus4.i_crc_req_ready) begin
                seen_ids.push_back(int'(exp_q[0][37:36]));
                void'(exp_q.pop_front());
            end
        end
        g = -1;
        if (!m_full || bus4.i_crc_req_ready) begin
            for (int j = 0; j < NCH; j++) begin
                c = (m_rr + j) % NCH;
                if (g < 0 && bus4.i_ch_req_valid[c] && m_cnt[c] < 4) g = c;
            end
        end
        exp_rdy = (g >= 0) ? 4'(1 << g) : 4'b0;
        chk("ch_req_ready", bus4.o_ch_req_ready, exp_rdy);

        id     = int'(bus4.i_crc_done_data[150:149]);
        exp_dv = bus4.i_crc_done_valid ? 4'(1 << id) : 4'b0;
        exp_dr = bus4.i_ch_done_ready[id];
        chk("ch_done_valid", bus4.o_ch_done_valid, exp_dv);
        chk("crc_done_ready", bus4.o_crc_done_ready, exp_dr);
        if (bus4.i_crc_done_valid) begin
            chk("ch_done_data", bus4.o_ch_done_data, bus4.i_crc_done_data[148:0]);
        end
        chk("int_pend", bus4.o_int_pend, m_pend);
        chk("err", bus4.o_err, m_err);
`ifdef CRC_ARB_TIMEOUT_EN
        chk("int", bus4.o_int, m_int | m_to);
        chk("timeout", timeout, m_to);
`else
        chk("int", bus4.o_int, m_int);
`endif

        hs = (bus4.i_crc_done_valid && exp_dr) ? exp_dv : 4'b0;
        any_out = 1'b0;
        for (int k = 0; k < NCH; k++) if (m_cnt[k] > 0) any_out = 1'b1;
`ifdef CRC_ARB_TIMEOUT_EN
        if ((|hs) || !any_out) m_wd = 0;
        else if (m_wd < 16) begin
            m_wd++;
            if (m_wd == 16) m_to = 1'b1;
        end
`endif
        for (int k = 0; k < NCH; k++) begin
            if (hs[k] && m_cnt[k] == 0) m_err = 1'b1;
            if (g == k && !hs[k]) m_cnt[k]++;
            else if (hs[k] && g != k && m_cnt[k] > 0) m_cnt[k]--;
        end
        m_int  = |(m_pend & bus4.i_int_mask);
        m_pend = (m_pend & ~bus4.i_int_clr) | hs;
        if (g >= 0) begin
            exp_q.push_back({2'(g), bus4.i_ch_req_data[g*RQW +: RQW]});
            m_rr   = (g + 1) % NCH;
            m_full = 1'b1;
        end else if (bus4.i_crc_req_ready) begin
            m_full = 1'b0;
        end
        @(posedge clk);
        #1;
        new_req_data();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus4.i_ch_req_valid = '1;
        bus3.i_ch_req_valid = '1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_ch_req_ready", bus4.o_ch_req_ready, 4'b0);
        chk("rst_ch_req_ready3", bus3.o_ch_req_ready, 3'b0);
        chk("rst_req_valid", bus4.o_crc_req_valid, 1'b0);
        chk("rst_int_pend", bus4.o_int_pend, 4'b0);
        chk("rst_int", bus4.o_int, 1'b0);
        chk("rst_err", bus4.o_err, 1'b0);
`ifdef CRC_ARB_TIMEOUT_EN
        chk("rst_timeout", timeout, 1'b0);
`endif
        rst = 1'b0;
        bus4.i_ch_req_valid = '0;
        bus4.i_crc_req_ready = 1'b0;
        bus4.i_int_mask = '0;
        bus4.i_int_clr = '0;
        set_done(1'b0, 0, 4'b0);
        bus3.i_ch_req_valid = '0;
        bus3.i_crc_done_valid = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
    endtask

    initial begin
        bus4.i_ch_req_valid = '0;
        bus4.i_ch_req_data  = '0;
        bus4.i_crc_req_ready = 1'b0;
        bus4.i_int_mask = '0;
        bus4.i_int_clr  = '0;
        set_done(1'b0, 0, 4'b0);
        bus3.i_ch_req_valid = '0;
        bus3.i_ch_req_data  = '0;
        bus3.i_crc_req_ready = 1'b0;
        bus3.i_crc_done_valid = 1'b0;
        bus3.i_crc_done_data  = '0;
        bus3.i_ch_done_ready  = '0;
        bus3.i_int_mask = '0;
        bus3.i_int_clr  = '0;
        new_req_data();

        // Round-robin fairness, one beat per cycle
        do_reset();
        seen_ids.delete();
        bus4.i_ch_req_valid  = 4'hF;
        bus4.i_crc_req_ready = 1'b1;
        repeat (9) tick();
        chk("rr_beats", seen_ids.size(), 8);
        for (int i = 0; i < 8 && i < seen_ids.size(); i++) begin
            chk("rr_order", seen_ids[i], i % 4);
        end

        // Backpressure with ch2 held in the stage
        do_reset();
        bus4.i_ch_req_valid  = 4'hF;
        bus4.i_crc_req_ready = 1'b1;
        repeat (3) tick();
        bus4.i_crc_req_ready = 1'b0;
        repeat (5) tick();
        chk("bp_held_ch2", bus4.o_crc_req_data[37:36], 2'd2);
        bus4.i_crc_req_ready = 1'b1;
        tick();
        chk("bp_next_ch3", bus4.o_crc_req_data[37:36], 2'd3);
        repeat (2) tick();

        // Outstanding limit on ch1
        do_reset();
        bus4.i_ch_req_valid  = 4'b0010;
        bus4.i_crc_req_ready = 1'b1;
        repeat (6) tick();
        chk("limit_blocked", bus4.o_ch_req_ready[1], 1'b0);
        set_done(1'b1, 1, 4'b0010);
        tick();
        set_done(1'b0, 0, 4'b0);
        chk("limit_regrant", bus4.o_ch_req_ready[1], 1'b1);
        repeat (2) tick();

        // Completion routing, backpressure, interrupt
        do_reset();
        bus4.i_int_mask      = 4'b0100;
        bus4.i_crc_req_ready = 1'b1;
        bus4.i_ch_req_valid  = 4'b0100;
        tick();
        bus4.i_ch_req_valid  = 4'b0;
        tick();
        set_done(1'b1, 2, 4'b0000);
        repeat (2) tick();
        bus4.i_ch_done_ready = 4'b0100;
        tick();
        set_done(1'b0, 0, 4'b0);
        repeat (2) tick();
        chk("route_pend2", bus4.o_int_pend, 4'b0100);
        chk("route_int", bus4.o_int, 1'b1);
        bus4.i_int_clr = 4'b0100;
        tick();
        bus4.i_int_clr = 4'b0;
        repeat (2) tick();

        // Completion to an idle channel, then set/clear collision on ch0
        set_done(1'b1, 0, 4'b0001);
        tick();
        set_done(1'b0, 0, 4'b0);
        tick();
        chk("idle_done_err", bus4.o_err, 1'b1);
        set_done(1'b1, 0, 4'b0001);
        bus4.i_int_clr = 4'b0001;
        tick();
        set_done(1'b0, 0, 4'b0);
        bus4.i_int_clr = 4'b0;
        tick();
        chk("set_wins", bus4.o_int_pend[0], 1'b1);

        // Reset mid-operation, late completion becomes an error
        bus4.i_crc_req_ready = 1'b0;
        bus4.i_ch_req_valid  = 4'b1000;
        tick();
        bus4.i_ch_req_valid  = 4'b0;
        tick();
        do_reset();
        set_done(1'b1, 3, 4'b1000);
        tick();
        set_done(1'b0, 0, 4'b0);
        repeat (2) tick();
        chk("late_done_err", bus4.o_err, 1'b1);

        // Out-of-range channel tag on the three-channel instance
        do_reset();
        bus3.i_crc_done_valid = 1'b1;
        bus3.i_crc_done_data  = {2'd3, 149'h5a5a};
        @(negedge clk);
        chk("bad_id_err_before", bus3.o_err, 1'b0);
        chk("bad_id_ready", bus3.o_crc_done_ready, 1'b1);
        chk("bad_id_valid", bus3.o_ch_done_valid, 3'b000);
        @(posedge clk);
        #1;
        bus3.i_crc_done_valid = 1'b0;
        @(negedge clk);
        chk("bad_id_err", bus3.o_err, 1'b1);
        @(posedge clk);
        #1;

`ifdef CRC_ARB_TIMEOUT_EN
        // Watchdog: one request outstanding, never completed
        do_reset();
        bus4.i_crc_req_ready = 1'b1;
        bus4.i_ch_req_valid  = 4'b0001;
        tick();
        bus4.i_ch_req_valid  = 4'b0;
        repeat (14) tick();
        chk("wd_not_yet", timeout, 1'b0);
        repeat (4) tick();
        chk("wd_timeout", timeout, 1'b1);
        chk("wd_int", bus4.o_int, 1'b1);
        do_reset();
        chk("wd_cleared", timeout, 1'b0);
        chk("wd_int_cleared", bus4.o_int, 1'b0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
